// File: rtl/imem_responder.sv
// Fetch-side instruction memory responder: one outstanding fetch, fixed latency,
// valid/ready request and response channels, flush on redirect, side load port.
module imem_responder #(
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic        flush,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = ($clog2(LATENCY + 1) > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // off is the 32-bit unsigned difference from BASE_ADDR; wrap below base is caught by a < BASE_ADDR.
  function automatic logic addr_bad(input logic [31:0] a, input logic [31:0] off);
    return (a[1:0] != 2'b00) || (a < BASE_ADDR) || ({1'b0, off} >= SPAN_BYTES);
  endfunction

  logic [31:0] mem [DEPTH_WORDS];

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;

  logic [31:0]        samp_addr_s;
  logic [31:0]        samp_off_s;
  logic               samp_err_s;
  logic [IDX_W-1:0]   samp_idx_s;
  logic [31:0]        samp_data_s;

  logic [31:0]        ld_off_s;
  logic               ld_bad_s;
  logic [IDX_W-1:0]   ld_idx_s;

  // Read-side address decode; with LATENCY 1 the sample is taken from the live request.
  always_comb begin
    samp_addr_s = (state_q == ST_IDLE) ? req_addr : addr_q;
    samp_off_s  = samp_addr_s - BASE_ADDR;
    samp_err_s  = addr_bad(samp_addr_s, samp_off_s);
    samp_idx_s  = samp_off_s[IDX_W+1:2];
    if (samp_err_s) begin
      samp_data_s = 32'h0000_0000;
    end else begin
      samp_data_s = mem[samp_idx_s];
    end
  end

  // Load-port address decode.
  always_comb begin
    ld_off_s = ld_addr - BASE_ADDR;
    ld_bad_s = addr_bad(ld_addr, ld_off_s);
    ld_idx_s = ld_off_s[IDX_W+1:2];
  end

  // Array write; non-blocking update gives read-before-write on a same-edge sample.
  always_ff @(posedge clk) begin
    if (ld_en && !ld_bad_s) begin
      mem[ld_idx_s] <= ld_data;
    end
  end

  // Next-state and response register inputs; flush overrides everything.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (req_valid) begin
          addr_d = req_addr;
          if (LATENCY == 1) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = samp_data_s;
            rsp_err_d   = samp_err_s;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end else if (cnt_q == {CNT_W{1'b0}}) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = samp_data_s;
          rsp_err_d   = samp_err_s;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_RESP: begin
        if (flush || rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cnt_d       = {CNT_W{1'b0}};
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State, counter and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      addr_q      <= 32'h0000_0000;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench: a LATENCY=2 instance for fetch/error/flush/reset scenarios and a
// LATENCY=1 instance for streaming; both share clock, reset and the load port.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        ld_en = 1'b0;
  logic [31:0] ld_addr = 32'h0;
  logic [31:0] ld_data = 32'h0;

  logic        req_valid2 = 1'b0, req_ready2, rsp_valid2, rsp_ready2 = 1'b1, rsp_err2;
  logic [31:0] req_addr2 = 32'h0, rsp_data2;
  logic        req_valid1 = 1'b0, req_ready1, rsp_valid1, rsp_ready1 = 1'b1, rsp_err1;
  logic [31:0] req_addr1 = 32'h0, rsp_data1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imem_responder #(.LATENCY(2), .DEPTH_WORDS(4096), .BASE_ADDR(32'h8000_0000)) u_l2 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2), .req_addr(req_addr2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_data(rsp_data2), .rsp_err(rsp_err2),
    .flush(flush), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  imem_responder #(.LATENCY(1), .DEPTH_WORDS(4096), .BASE_ADDR(32'h8000_0000)) u_l1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1), .rsp_err(rsp_err1),
    .flush(flush), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // Present a request to the LATENCY=2 instance; returns 1ns after the accepting edge E0.
  task automatic issue2(input logic [31:0] a);
    @(posedge clk); #1;
    req_valid2 = 1'b1; req_addr2 = a;
    @(posedge clk); #1;
    req_valid2 = 1'b0;
  endtask

  // Bounded wait for rsp_valid2, sampled on negedges; a timeout is a failed comparison.
  task automatic wait_valid2(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid2 === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_timeout: rsp_valid=%b required 1 within 10 cycles", name, rsp_valid2);
    end
  endtask

  task automatic test_reset();
    #3;
    n_tests++;
    if ({req_ready2, rsp_valid2, rsp_err2} !== 3'b100 || rsp_data2 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy/vld/err=%b%b%b data=%h required 100 data 00000000",
               req_ready2, rsp_valid2, rsp_err2, rsp_data2);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    load(32'h8000_0000, 32'h0000_0413);
    rsp_ready2 = 1'b1;
    issue2(32'h8000_0000);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_tests++;
      if (rsp_valid2 !== (k == 2) || req_ready2 !== (k == 3)) begin
        n_fail++;
        $display("FAIL basic_timing_E%0d: vld=%b rdy=%b required vld=%b rdy=%b",
                 k, rsp_valid2, req_ready2, (k == 2), (k == 3));
      end
      if (k == 2) begin
        n_tests++;
        if (rsp_data2 !== 32'h0000_0413 || rsp_err2 !== 1'b0) begin
          n_fail++;
          $display("FAIL basic_data: data=%h err=%b required 00000413 err=0", rsp_data2, rsp_err2);
        end
      end
      if (k < 3) @(posedge clk);
    end
  endtask

  task automatic test_backpressure();
    load(32'h8000_0010, 32'hDEAD_BEEF);
    rsp_ready2 = 1'b0;
    issue2(32'h8000_0010);
    wait_valid2("bp");
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      n_tests++;
      if (rsp_valid2 !== 1'b1 || rsp_data2 !== 32'hDEAD_BEEF || req_ready2 !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: vld=%b data=%h rdy=%b required 1 deadbeef 0",
                 k, rsp_valid2, rsp_data2, req_ready2);
      end
    end
    rsp_ready2 = 1'b1;
    @(negedge clk);
    n_tests++;
    if (rsp_valid2 !== 1'b0 || req_ready2 !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: vld=%b rdy=%b required vld=0 rdy=1", rsp_valid2, req_ready2);
    end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [4];
    logic        errs  [4];
    logic [31:0] datas [4];
    addrs = '{32'h8000_0002, 32'h7FFF_FFFC, 32'h8000_4000, 32'h8000_3FFC};
    errs  = '{1'b1, 1'b1, 1'b1, 1'b0};
    datas = '{32'h0, 32'h0, 32'h0, 32'h1234_5678};
    load(32'h8000_3FFC, 32'h1234_5678);
    rsp_ready2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue2(addrs[i]);
      wait_valid2("err");
      n_tests++;
      if (rsp_err2 !== errs[i] || rsp_data2 !== datas[i]) begin
        n_fail++;
        $display("FAIL err_%h: err=%b data=%h required err=%b data=%h",
                 addrs[i], rsp_err2, rsp_data2, errs[i], datas[i]);
      end
    end
  endtask

  task automatic test_flush();
    int bad;
    // Flush while waiting: the response must never appear.
    rsp_ready2 = 1'b1;
    issue2(32'h8000_0000);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid2 !== 1'b0 || req_ready2 !== 1'b1) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL flush_wait: %0d cycles with vld!=0 or rdy!=1, required 0", bad);
    end
    // Flush while holding a response.
    rsp_ready2 = 1'b0;
    issue2(32'h8000_0000);
    wait_valid2("flush_resp");
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    n_tests++;
    if (rsp_valid2 !== 1'b0 || req_ready2 !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_resp: vld=%b rdy=%b required vld=0 rdy=1", rsp_valid2, req_ready2);
    end
    rsp_ready2 = 1'b1;
    // Flush together with a request in IDLE: not accepted.
    @(posedge clk); #1;
    flush = 1'b1; req_valid2 = 1'b1; req_addr2 = 32'h8000_0000;
    @(posedge clk); #1;
    flush = 1'b0; req_valid2 = 1'b0;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid2 !== 1'b0 || req_ready2 !== 1'b1) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL flush_idle: %0d cycles with vld!=0 or rdy!=1, required 0", bad);
    end
  endtask

  task automatic test_stream();
    load(32'h8000_0000, 32'h1);
    load(32'h8000_0004, 32'h2);
    load(32'h8000_0008, 32'h3);
    rsp_ready1 = 1'b1;
    @(posedge clk); #1;
    req_valid1 = 1'b1; req_addr1 = 32'h8000_0000;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (k == 0) req_addr1 = 32'h8000_0004;
      if (k == 2) req_addr1 = 32'h8000_0008;
      if (k == 4) req_valid1 = 1'b0;
      @(negedge clk);
      n_tests++;
      if (rsp_valid1 !== (k % 2 == 0) || req_ready1 !== (k % 2 == 1)) begin
        n_fail++;
        $display("FAIL stream_timing_E%0d: vld=%b rdy=%b required vld=%b rdy=%b",
                 k, rsp_valid1, req_ready1, (k % 2 == 0), (k % 2 == 1));
      end
      if (k % 2 == 0) begin
        n_tests++;
        if (rsp_data1 !== 32'(k / 2 + 1) || rsp_err1 !== 1'b0) begin
          n_fail++;
          $display("FAIL stream_data_%0d: data=%h err=%b required %h err=0",
                   k / 2, rsp_data1, rsp_err1, 32'(k / 2 + 1));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    rsp_ready2 = 1'b1;
    issue2(32'h8000_0000);
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (rsp_valid2 !== 1'b0 || req_ready2 !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_wait: vld=%b rdy=%b required vld=0 rdy=1", rsp_valid2, req_ready2);
    end
    @(negedge clk);
    rst = 1'b1;
    // Reset while a response is pending must clear the registered outputs at once.
    rsp_ready2 = 1'b0;
    issue2(32'h8000_0010);
    wait_valid2("areset_pre");
    #1 rst = 1'b0;
    #1;
    n_tests++;
    if (rsp_valid2 !== 1'b0 || rsp_data2 !== 32'h0 || req_ready2 !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_resp: vld=%b data=%h rdy=%b required 0 00000000 1",
               rsp_valid2, rsp_data2, req_ready2);
    end
    @(negedge clk);
    rst = 1'b1;
    rsp_ready2 = 1'b1;
    issue2(32'h8000_0004);
    wait_valid2("areset_post");
    n_tests++;
    if (rsp_data2 !== 32'h2 || rsp_err2 !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_refetch: data=%h err=%b required 00000002 err=0", rsp_data2, rsp_err2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_errors();
    test_flush();
    test_stream();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
